shift_seq: RTL and testbench
============================

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameters: none; data width fixed at 16 bits, shift amount fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 shift_in  input  16  operand captured on accepted start.
REQ-006 shift_op  input  2  00 none, 01 logical left, 10 logical right, 11 arithmetic right (MSB replicated); captured on accepted start.
REQ-007 shift_amt  input  4  number of 1-bit positions, 0..15; captured on accepted start.
REQ-008 busy  output  1  high in SHIFT and DONE states.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 shift_out  output  16  working/result register, always driven from registered state.
REQ-011 carry  output  1  last bit shifted out; port present only with SHIFT_SEQ_CARRY_EN.

Function
REQ-012 Three states SHALL exist: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at edge E0 SHALL load shift_out<=shift_in, latch op, count<=shift_amt.
REQ-014 At E0, if shift_op=00 or shift_amt=0, next state SHALL be DONE; otherwise SHIFT.
REQ-015 Each SHIFT edge SHALL move shift_out one position per latched op and decrement count.
REQ-016 Left shift fills bit0 with 0; logical right fills bit15 with 0; arithmetic right fills bit15 with the current bit15.
REQ-017 SHIFT edge with count=1 SHALL perform the final shift and go to DONE; total SHIFT edges equal shift_amt exactly.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE on the next edge.
REQ-019 Latency: done high in the cycle after edge E(N), N = latched amount (N=0 when op=00), i.e. N+1 edges after E0.
REQ-020 shift_out SHALL hold the result after DONE until the next accepted start.
REQ-021 start while busy=1 SHALL be ignored with no effect on state, count or data.
REQ-022 start held high continuously SHALL be accepted again on the first IDLE edge after DONE (back-to-back, one IDLE cycle between operations).
REQ-023 Input changes after E0 SHALL not affect the operation in progress.
REQ-024 done and busy SHALL never depend combinationally on start.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, busy=0, done=0, shift_out=16'h0000, count=0, carry=0, without waiting for clk.
REQ-026 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 First start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro SHIFT_SEQ_CARRY_EN defined: carry port exists; cleared at E0; each SHIFT edge loads the bit shifted out (bit15 for left, bit0 for right/arithmetic right); stays 0 when N=0; held until next accepted start.
REQ-029 Macro SHIFT_SEQ_CARRY_EN undefined: carry port and its register SHALL not exist; all other behaviour identical.

Verification
REQ-030 shift_in=16'hF0CF, op=01, amt=1 -> done 2 edges after E0, shift_out=16'hE19E, carry=1.
REQ-031 shift_in=16'hF0CF, op=10, amt=4 -> done 5 edges after E0, shift_out=16'h0F0C, carry=1; op=11 same operand -> 16'hFF0C.
REQ-032 shift_in=16'h0001, op=01, amt=15 -> busy 16 cycles, shift_out=16'h8000; op=00 amt=7 on 16'h2273 -> done 1 edge after E0, shift_out=16'h2273, carry=0.
REQ-033 start pulsed again 2 cycles into an amt=8 operation with different operands -> ignored; first result and timing unchanged.
REQ-034 rst asserted 3 cycles into amt=10 operation between clock edges -> outputs zero immediately, no done pulse; next start completes correctly.
REQ-035 start held high for three operations -> three done pulses, each separated by one IDLE cycle, each result correct; carry checked only with SHIFT_SEQ_CARRY_EN.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: sequential 16-bit shifter, one bit position per clock.
// Operations: none, logical left, logical right, arithmetic right.
// Optional carry output (last bit shifted out) enabled by defining
// SHIFT_SEQ_CARRY_EN; without it the carry port and register are absent.
module shift_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] shift_in,
  input  logic [1:0]  shift_op,
  input  logic [3:0]  shift_amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] shift_out
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic        carry
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_data;
  logic [15:0] w_data_nxt;
  logic [1:0]  r_op;
  logic [1:0]  w_op_nxt;
  logic [3:0]  r_count;
  logic [3:0]  w_count_nxt;
  logic [15:0] w_shifted;
  logic        w_shout_bit;

`ifdef SHIFT_SEQ_CARRY_EN
  logic        r_carry;
  logic        w_carry_nxt;
`endif

  // One-position shift of the working register per the latched op, plus the bit leaving it
  always_comb begin
    w_shifted   = r_data;
    w_shout_bit = 1'b0;
    unique case (r_op)
      OP_SLL: begin
        w_shifted   = {r_data[14:0], 1'b0};
        w_shout_bit = r_data[15];
      end
      OP_SRL: begin
        w_shifted   = {1'b0, r_data[15:1]};
        w_shout_bit = r_data[0];
      end
      OP_SRA: begin
        w_shifted   = {r_data[15], r_data[15:1]};
        w_shout_bit = r_data[0];
      end
      default: begin
        w_shifted   = r_data;
        w_shout_bit = 1'b0;
      end
    endcase
  end

  // Next-state and datapath next values; start only matters in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_op_nxt    = r_op;
    w_count_nxt = r_count;
`ifdef SHIFT_SEQ_CARRY_EN
    w_carry_nxt = r_carry;
`endif
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_data_nxt  = shift_in;
          w_op_nxt    = shift_op;
          w_count_nxt = shift_amt;
`ifdef SHIFT_SEQ_CARRY_EN
          w_carry_nxt = 1'b0;
`endif
          if ((shift_op == OP_NONE) || (shift_amt == 4'd0)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        w_data_nxt  = w_shifted;
        w_count_nxt = r_count - 4'd1;
`ifdef SHIFT_SEQ_CARRY_EN
        w_carry_nxt = w_shout_bit;
`endif
        if (r_count == 4'd1) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: working data, latched op and remaining count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_op    <= '0;
      r_count <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
    end
  end

`ifdef SHIFT_SEQ_CARRY_EN
  // Carry register: last bit shifted out, cleared on accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_carry_nxt;
    end
  end

  assign carry = r_carry;
`else
  // Shift-out bit only feeds the optional carry register
  logic w_unused;
  assign w_unused = w_shout_bit;
`endif

  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign shift_out = r_data;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq.
// Define SHIFT_SEQ_CARRY_EN for both RTL and bench to include carry checks.
`timescale 1ns/1ps
module tb_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] shift_in;
  logic [1:0]  shift_op;
  logic [3:0]  shift_amt;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
`ifdef SHIFT_SEQ_CARRY_EN
  logic        carry;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  shift_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift_in  (shift_in),
    .shift_op  (shift_op),
    .shift_amt (shift_amt),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out)
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    .carry     (carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; drives a start so the next
  // posedge is E0. Returns at the negedge of the IDLE cycle after DONE.
  // glitch >= 0 pulses a conflicting start at that cycle of the operation.
  task automatic run_op(input string tag, input logic [15:0] din,
                        input logic [1:0] op, input logic [3:0] amt,
                        input logic [15:0] exp_out, input logic exp_c,
                        input int exp_lat, input bit hold, input int glitch);
    int lat;
    int busy_cnt;
    lat      = 99;
    busy_cnt = 0;
    start     = 1'b1;
    shift_in  = din;
    shift_op  = op;
    shift_amt = amt;
    @(posedge clk);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (k == 0) begin
        // change operands after E0: must not disturb the running operation
        shift_in  = ~din;
        shift_op  = ~op;
        shift_amt = ~amt;
        if (!hold) start = 1'b0;
      end
      if (glitch >= 0 && k == glitch) begin
        start     = 1'b1;
        shift_in  = 16'hFFFF;
        shift_op  = 2'b10;
        shift_amt = 4'd1;
      end
      if (glitch >= 0 && k == glitch + 1) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat + 1);
    check({tag, "_out"}, shift_out, exp_out);
`ifdef SHIFT_SEQ_CARRY_EN
    check({tag, "_carry"}, carry, exp_c);
`else
    if (exp_c === 1'bx) $display("note: %s carry expectation unknown", tag);
`endif
    @(negedge clk);
    check({tag, "_done_pulse_end"}, done, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_held"}, shift_out, exp_out);
  endtask

  int done_seen;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    shift_in  = '0;
    shift_op  = '0;
    shift_amt = '0;
    #1 rst = 1'b1;
    #1;
    // asynchronous reset values before any clock edge
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", shift_out, 16'h0000);
`ifdef SHIFT_SEQ_CARRY_EN
    check("rst_carry", carry, 1'b0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("sll1",   16'hF0CF, 2'b01, 4'd1,  16'hE19E, 1'b1, 1,  0, -1);
    run_op("srl4",   16'hF0CF, 2'b10, 4'd4,  16'h0F0C, 1'b1, 4,  0, -1);
    run_op("sra4",   16'hF0CF, 2'b11, 4'd4,  16'hFF0C, 1'b1, 4,  0, -1);
    run_op("sll15",  16'h0001, 2'b01, 4'd15, 16'h8000, 1'b0, 15, 0, -1);
    run_op("none7",  16'h2273, 2'b00, 4'd7,  16'h2273, 1'b0, 0,  0, -1);
    run_op("sll0",   16'h1234, 2'b01, 4'd0,  16'h1234, 1'b0, 0,  0, -1);
    run_op("srl3",   16'h00AB, 2'b10, 4'd3,  16'h0015, 1'b0, 3,  0, -1);
    run_op("sra15",  16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0, 15, 0, -1);
    run_op("ignore", 16'h0F0F, 2'b01, 4'd8,  16'h0F00, 1'b1, 8,  0, 2);

    // reset between edges, 3 cycles into a 10-shift operation
    start     = 1'b1;
    shift_in  = 16'hFFFF;
    shift_op  = 2'b10;
    shift_amt = 4'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out", shift_out, 16'h0000);
`ifdef SHIFT_SEQ_CARRY_EN
    check("abort_carry", carry, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op("after_rst", 16'hF0CF, 2'b11, 4'd4, 16'hFF0C, 1'b1, 4, 0, -1);

    // start held high: back-to-back operations, one IDLE cycle apart
    run_op("b2b_a", 16'h1234, 2'b01, 4'd4, 16'h2340, 1'b1, 4, 1, -1);
    run_op("b2b_b", 16'h8421, 2'b11, 4'd2, 16'hE108, 1'b0, 2, 1, -1);
    run_op("b2b_c", 16'hBEEF, 2'b00, 4'd3, 16'hBEEF, 1'b0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
